ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch.sv | 133 +++++++++++++
 tb/tb_ifu_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: PC, one-outstanding imem request, decode handshake
// Optional misaligned-redirect check enabled by defining IFU_MISALIGN_CHK_EN.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_err
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            inst_err_q, inst_err_d;
    logic [XLEN-1:0] redir_pc;
    logic            misalign;

`ifdef IFU_MISALIGN_CHK_EN
    assign redir_pc = redirect_pc;
    assign misalign = (pc_q[1:0] != 2'b00);
`else
    logic unused_redir_lo;
    assign unused_redir_lo = ^redirect_pc[1:0];
    assign redir_pc        = {redirect_pc[XLEN-1:2], 2'b00};
    assign misalign        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= RESET_PC;
            inst_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_err_q   <= inst_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_err_d   = inst_err_q;
        case (state_q)
            S_REQ: begin
                if (misalign) begin
                    // A misaligned PC never reaches memory; a nop carrying the error goes to decode.
                    if (redirect_valid) begin
                        pc_d = redir_pc;
                    end else begin
                        state_d      = S_HOLD;
                        inst_d       = 32'h0000_0013;
                        inst_pc_d    = pc_q;
                        inst_err_d   = 1'b1;
                        inst_valid_d = 1'b1;
                    end
                end else begin
                    if (redirect_valid) pc_d = redir_pc;
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = redirect_valid;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d   = redir_pc;
                    drop_d = 1'b1;
                end
                if (imem_resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d       = imem_resp_data;
                        inst_pc_d    = pc_q;
                        inst_err_d   = 1'b0;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (inst_ready || redirect_valid) begin
                    inst_valid_d = 1'b0;
                    inst_err_d   = 1'b0;
                    pc_d         = redirect_valid ? redir_pc : pc_q + 32'd4;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = rst_n && (state_q == S_REQ) && !misalign;
        imem_req_addr  = pc_q;
        inst_valid     = inst_valid_q;
        inst           = inst_q;
        inst_pc        = inst_pc_q;
        inst_err       = inst_err_q;
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed bench for ifu_fetch with memory responder and scoreboard
module tb_ifu_fetch;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_err;

    int          ncmp = 0;
    int          nfail = 0;
    exp_t        sb[$];
    logic [31:0] req_log[$];
    logic        outstanding = 1'b0;
    logic        stale = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          wait_cnt = 0;
    int          resp_lag = 0;
    logic        seen_dead = 1'b0;
    logic        stable_ok;
    logic [31:0] hold_inst, hold_pc;

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_err(inst_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_for(input logic [31:0] a);
        return 32'h0010_0093 ^ (a << 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Observe at the falling edge, then drive the memory response just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (inst_valid && inst === 32'hDEAD_BEEF) seen_dead = 1'b1;
        if (outstanding && redirect_valid) stale = 1'b1;
        if (imem_resp_valid) begin
            if (!stale) sb.push_back('{data: imem_resp_data, pc: pend_addr, err: 1'b0});
            outstanding = 1'b0;
            stale = 1'b0;
        end
        if (inst_valid && inst_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk("inst", inst, e.data);
                chk("inst_pc", inst_pc, e.pc);
                chk("inst_err", {31'b0, inst_err}, {31'b0, e.err});
            end
        end else if (inst_valid && redirect_valid && sb.size() != 0) begin
            void'(sb.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            outstanding = 1'b1;
            stale = redirect_valid;
            pend = 1'b1;
            pend_addr = imem_req_addr;
            wait_cnt = resp_lag;
            req_log.push_back(imem_req_addr);
        end
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        if (pend) begin
            if (wait_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data = stale ? 32'hDEAD_BEEF : data_for(pend_addr);
                pend = 1'b0;
            end else begin
                wait_cnt--;
            end
        end
    endtask

    task automatic wait_hold();
        for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) tick();
        chk("wait_hold_timeout", {31'b0, inst_valid}, 32'd1);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && imem_req_valid !== 1'b1; i++) tick();
        chk("wait_req_timeout", {31'b0, imem_req_valid}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h8000_0000);
        chk("rst_inst_err", {31'b0, inst_err}, 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        chk("lat_cycle1_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("lat_cycle2_valid", {31'b0, inst_valid}, 32'd1);
        chk("first_inst", inst, 32'h0010_0093);
        chk("first_inst_pc", inst_pc, 32'h8000_0000);

        // Decode stalls for five cycles.
        stable_ok = 1'b1;
        hold_inst = inst;
        hold_pc = inst_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (inst !== hold_inst || inst_pc !== hold_pc || inst_valid !== 1'b1 || imem_req_valid !== 1'b0)
                stable_ok = 1'b0;
        end
        chk("hold_stable", {31'b0, stable_ok}, 32'd1);
        inst_ready = 1'b1;
        tick();
        chk("after_hold_addr", imem_req_addr, 32'h8000_0004);

        req_log.delete();
        repeat (10) tick();
        chk("seq_count", {31'b0, req_log.size() >= 3}, 32'd1);
        if (req_log.size() >= 3) begin
            chk("seq_addr0", req_log[0], 32'h8000_0004);
            chk("seq_addr1", req_log[1], 32'h8000_0008);
            chk("seq_addr2", req_log[2], 32'h8000_000C);
        end

        // Redirect while waiting for a slow response.
        resp_lag = 2;
        wait_req();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        wait_req();
        chk("wait_redirect_addr", imem_req_addr, 32'h8000_0100);
        resp_lag = 0;

        // Redirect coincident with consume.
        inst_ready = 1'b0;
        wait_hold();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0040;
        inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("consume_redirect_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("consume_redirect_addr", imem_req_addr, 32'h8000_0040);

        // PC wrap at the top of the address space.
        inst_ready = 1'b0;
        wait_hold();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_hold();
        chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        tick();
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);

        // Misaligned redirect from HOLD.
        inst_ready = 1'b0;
        wait_hold();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0042;
        tick();
        redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        chk("mis_no_req", {31'b0, imem_req_valid}, 32'd0);
        sb.push_back('{data: 32'h0000_0013, pc: 32'h8000_0042, err: 1'b1});
        tick();
        chk("mis_valid", {31'b0, inst_valid}, 32'd1);
        chk("mis_err", {31'b0, inst_err}, 32'd1);
        chk("mis_inst", inst, 32'h0000_0013);
        chk("mis_pc", inst_pc, 32'h8000_0042);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0000;
        tick();
        redirect_valid = 1'b0;
        chk("mis_err_clear", {31'b0, inst_err}, 32'd0);
        chk("mis_after_addr", imem_req_addr, 32'h8000_0000);
`else
        chk("mis_forced_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("mis_forced_addr", imem_req_addr, 32'h8000_0040);
        chk("mis_err_tied", {31'b0, inst_err}, 32'd0);
`endif

        // Reset while a response is still in flight.
        inst_ready = 1'b1;
        resp_lag = 1;
        wait_req();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("midrst_inst_pc", inst_pc, 32'h8000_0000);
        sb.delete();
        if (outstanding) stale = 1'b1;
        imem_req_ready = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("postrst_outstanding", {31'b0, outstanding}, 32'd0);
        chk("postrst_addr", imem_req_addr, 32'h8000_0000);
        chk("postrst_no_inst", {31'b0, inst_valid}, 32'd0);
        imem_req_ready = 1'b1;
        resp_lag = 0;
        wait_hold();
        chk("postrst_inst", inst, data_for(32'h8000_0000));
        tick();

        chk("stale_never_shown", {31'b0, seen_dead}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
